// File: rtl/hyperbus_burst_ctrl.sv
// hyperbus_burst_ctrl
// HyperBus leader controller. Runs linear multi-word bursts to one chip select
// through a DDR PHY that takes {rise, fall} half-word pairs. A burst is split
// into several CS-low chunks when the CS-low time limit is reached or when
// write data runs dry. Reads give up after a fixed number of strobe-less cycles.
module hyperbus_burst_ctrl #(
  parameter int WIDTH           = 8,
  parameter int NCS             = 2,
  parameter int ADDR_LENGTH     = 32,
  parameter int LEN_WIDTH       = 8,
  parameter int LAT_CYCLES      = 6,
  parameter int FIXED_LATENCY   = 0,
  parameter int MAX_CS_CYCLES   = 64,
  parameter int RECOVERY_CYCLES = 2,
  parameter int RESET_COUNT     = 4,
  parameter int TIMEOUT_CYCLES  = 32,
  localparam int CS_W           = (NCS > 1) ? $clog2(NCS) : 1,
  localparam int MW             = 2 * WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic                   req_reg_space,
  input  logic [CS_W-1:0]        req_cs,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]   req_len,
  input  logic [2*WIDTH-1:0]     wdat,
  input  logic [MW-1:0]          wmask,
  input  logic                   wdat_valid,
  output logic                   wdat_ready,
  output logic [2*WIDTH-1:0]     rdat,
  output logic                   rdat_valid,
  output logic                   done,
  output logic                   err,
  output logic                   phy_clk_en,
  output logic                   phy_rstn,
  output logic [NCS-1:0]         phy_csn,
  output logic [2*WIDTH-1:0]     phy_dq_o,
  output logic                   phy_dq_oe,
  input  logic [2*WIDTH-1:0]     phy_dq_i,
  output logic [MW-1:0]          phy_rwds_o,
  output logic                   phy_rwds_oe,
  input  logic [1:0]             phy_rwds_i
);

  localparam int CNT_W = 8;
  localparam int CSC_W = $clog2(MAX_CS_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAT_1X = CNT_W'(LAT_CYCLES);
  localparam logic [CNT_W-1:0] LAT_2X = CNT_W'(2 * LAT_CYCLES);
  localparam logic [CS_W:0]    NCS_V  = (CS_W + 1)'(NCS);

  typedef enum logic [2:0] {
    S_RESET   = 3'd0,
    S_IDLE    = 3'd1,
    S_CMD     = 3'd2,
    S_LATENCY = 3'd3,
    S_WRITE   = 3'd4,
    S_READ    = 3'd5,
    S_RECOVER = 3'd6
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, r_lat, w_lat_sel;
  logic [CSC_W-1:0]       r_cs_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [ADDR_LENGTH-1:0] r_addr;
  logic [LEN_WIDTH-1:0]   r_rem;
  logic [CS_W-1:0]        r_cs, w_req_cs;
  logic                   r_write, r_reg, r_timeout, r_zero_done, r_rdat_valid;
  logic [2*WIDTH-1:0]     r_rdat;
  logic [47:0]            w_ca;
  logic                   w_active, w_accept, w_wr_xfer, w_rd_xfer, w_xfer, w_last_word;
  logic                   w_cs_limit, w_timeout, w_chunk_end, w_rec_end, w_finish;

  // Command/address word for a linear burst starting at the given word address
  function automatic logic [47:0] ca_word(input logic [ADDR_LENGTH-1:0] addr,
                                          input logic write, input logic reg_space);
    logic [47:0] ca;
    ca                        = 48'd0;
    ca[47]                    = ~write;
    ca[46]                    = reg_space;
    ca[45]                    = 1'b1;
    ca[16 +: ADDR_LENGTH - 3] = addr[ADDR_LENGTH-1:3];
    ca[2:0]                   = addr[2:0];
    return ca;
  endfunction

  // Shared transfer and chunk-close conditions for next-state and datapath
  always_comb begin
    w_ca        = ca_word(r_addr, r_write, r_reg);
    w_active    = (r_state == S_CMD) || (r_state == S_LATENCY) ||
                  (r_state == S_WRITE) || (r_state == S_READ);
    w_accept    = (r_state == S_IDLE) && !r_zero_done && req_valid;
    w_wr_xfer   = (r_state == S_WRITE) && wdat_valid;
    w_rd_xfer   = (r_state == S_READ) && (phy_rwds_i == 2'b10);
    w_xfer      = w_wr_xfer || w_rd_xfer;
    w_last_word = w_xfer && (r_rem == LEN_WIDTH'(1));
    w_cs_limit  = (r_cs_cnt == CSC_W'(MAX_CS_CYCLES - 1));
    w_timeout   = (r_state == S_READ) && !w_rd_xfer &&
                  (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    w_chunk_end = ((r_state == S_WRITE) && (w_last_word || !wdat_valid || w_cs_limit)) ||
                  ((r_state == S_READ) && (w_last_word || w_cs_limit || w_timeout));
    w_rec_end   = (r_state == S_RECOVER) && (r_cnt == CNT_W'(0));
    w_finish    = w_rec_end && ((r_rem == LEN_WIDTH'(0)) || r_timeout);
    if ((FIXED_LATENCY != 0) || (phy_rwds_i == 2'b11)) begin
      w_lat_sel = LAT_2X;
    end else begin
      w_lat_sel = LAT_1X;
    end
    if ({1'b0, req_cs} < NCS_V) begin
      w_req_cs = req_cs;
    end else begin
      w_req_cs = CS_W'(0);
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_RESET;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET:   w_state_nxt = (r_cnt == CNT_W'(0)) ? S_IDLE : S_RESET;
      S_IDLE:    w_state_nxt = (w_accept && (req_len != LEN_WIDTH'(0))) ? S_CMD : S_IDLE;
      S_CMD: begin
        if (r_cnt == CNT_W'(2)) begin
          w_state_nxt = (r_write && r_reg) ? S_WRITE : S_LATENCY;
        end else begin
          w_state_nxt = S_CMD;
        end
      end
      S_LATENCY: begin
        if (r_cnt == CNT_W'(0)) begin
          w_state_nxt = r_write ? S_WRITE : S_READ;
        end else begin
          w_state_nxt = S_LATENCY;
        end
      end
      S_WRITE:   w_state_nxt = w_chunk_end ? S_RECOVER : S_WRITE;
      S_READ:    w_state_nxt = w_chunk_end ? S_RECOVER : S_READ;
      S_RECOVER: begin
        if (w_rec_end) begin
          w_state_nxt = w_finish ? S_IDLE : S_CMD;
        end else begin
          w_state_nxt = S_RECOVER;
        end
      end
      default:   w_state_nxt = S_RESET;
    endcase
  end

  // Counters, request latch, address/length tracking and read capture
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= CNT_W'(RESET_COUNT);
      r_lat        <= LAT_1X;
      r_cs_cnt     <= CSC_W'(0);
      r_to_cnt     <= TO_W'(0);
      r_addr       <= ADDR_LENGTH'(0);
      r_rem        <= LEN_WIDTH'(0);
      r_cs         <= CS_W'(0);
      r_write      <= 1'b0;
      r_reg        <= 1'b0;
      r_timeout    <= 1'b0;
      r_zero_done  <= 1'b0;
      r_rdat       <= '0;
      r_rdat_valid <= 1'b0;
    end else begin
      case (r_state)
        S_RESET:   r_cnt <= (r_cnt == CNT_W'(0)) ? CNT_W'(0) : r_cnt - CNT_W'(1);
        S_CMD: begin
          if (r_cnt == CNT_W'(2)) begin
            r_cnt <= (r_write && r_reg) ? CNT_W'(0) : r_lat - CNT_W'(1);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_LATENCY: r_cnt <= (r_cnt == CNT_W'(0)) ? CNT_W'(0) : r_cnt - CNT_W'(1);
        S_WRITE,
        S_READ:    r_cnt <= w_chunk_end ? CNT_W'(RECOVERY_CYCLES - 1) : r_cnt;
        S_RECOVER: r_cnt <= (r_cnt == CNT_W'(0)) ? CNT_W'(0) : r_cnt - CNT_W'(1);
        default:   r_cnt <= CNT_W'(0);
      endcase
      // Latency choice comes from RWDS seen in the first CA cycle
      if ((r_state == S_CMD) && (r_cnt == CNT_W'(0))) r_lat <= w_lat_sel;
      r_cs_cnt     <= w_active ? r_cs_cnt + CSC_W'(1) : CSC_W'(0);
      r_to_cnt     <= ((r_state == S_READ) && !w_rd_xfer) ? r_to_cnt + TO_W'(1) : TO_W'(0);
      r_zero_done  <= w_accept && (req_len == LEN_WIDTH'(0));
      if (w_accept) begin
        r_addr    <= req_addr;
        r_rem     <= req_len;
        r_cs      <= w_req_cs;
        r_write   <= req_write;
        r_reg     <= req_reg_space;
        r_timeout <= 1'b0;
      end else if (w_xfer) begin
        r_addr <= r_addr + ADDR_LENGTH'(1);
        r_rem  <= r_rem - LEN_WIDTH'(1);
      end else if (w_timeout) begin
        r_timeout <= 1'b1;
      end
      r_rdat_valid <= w_rd_xfer;
      if (w_rd_xfer) r_rdat <= phy_dq_i;
    end
  end

  // FSM output decode
  always_comb begin
    req_ready   = 1'b0;
    wdat_ready  = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    phy_clk_en  = 1'b0;
    phy_rstn    = 1'b1;
    phy_csn     = '1;
    phy_dq_o    = '0;
    phy_dq_oe   = 1'b0;
    phy_rwds_o  = '0;
    phy_rwds_oe = 1'b0;
    rdat        = r_rdat;
    rdat_valid  = r_rdat_valid;
    if (w_active) begin
      phy_csn[r_cs] = 1'b0;
      phy_clk_en    = 1'b1;
    end else begin
      phy_clk_en    = 1'b0;
    end
    case (r_state)
      S_RESET: phy_rstn = 1'b0;
      S_IDLE: begin
        req_ready = !r_zero_done;
        done      = r_zero_done;
      end
      S_CMD: begin
        phy_dq_oe = 1'b1;
        case (r_cnt)
          CNT_W'(0): phy_dq_o[15:0] = w_ca[47:32];
          CNT_W'(1): phy_dq_o[15:0] = w_ca[31:16];
          default:   phy_dq_o[15:0] = w_ca[15:0];
        endcase
      end
      // RWDS is driven low one cycle ahead of write data as its preamble
      S_LATENCY: phy_rwds_oe = r_write && (r_cnt == CNT_W'(0));
      S_WRITE: begin
        phy_dq_oe   = 1'b1;
        phy_dq_o    = wdat;
        wdat_ready  = wdat_valid;
        phy_rwds_oe = !r_reg;
        if (wdat_valid) begin
          phy_rwds_o = wmask;
        end else begin
          phy_rwds_o = '1;
        end
      end
      S_RECOVER: begin
        done = w_finish;
        err  = w_finish && r_timeout;
      end
      default: phy_rstn = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// tb_hyperbus_burst_ctrl
// Directed bench: reset sequence, short write, double-latency read, split
// write on CS-low limit, split on write underflow, read timeout, zero length.
module tb_hyperbus_burst_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_reg_space;
  logic [0:0]  req_cs;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [15:0] wdat, rdat, phy_dq_o, phy_dq_i;
  logic [1:0]  wmask, phy_rwds_o, phy_rwds_i;
  logic        wdat_valid, wdat_ready, rdat_valid, done, err;
  logic        phy_clk_en, phy_rstn, phy_dq_oe, phy_rwds_oe;
  logic [1:0]  phy_csn;

  int n_checks = 0;
  int n_errors = 0;

  // observations of one transaction
  int          n_chunks, n_wr, n_rd, n_done, n_err, bad_data, bad_csn;
  int          first_wr_pos, done_cyc, done_gap, gap;
  int          chunk_len [2];
  logic [47:0] ca [2];

  hyperbus_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_reg_space(req_reg_space), .req_cs(req_cs), .req_addr(req_addr), .req_len(req_len),
    .wdat(wdat), .wmask(wmask), .wdat_valid(wdat_valid), .wdat_ready(wdat_ready),
    .rdat(rdat), .rdat_valid(rdat_valid), .done(done), .err(err),
    .phy_clk_en(phy_clk_en), .phy_rstn(phy_rstn), .phy_csn(phy_csn),
    .phy_dq_o(phy_dq_o), .phy_dq_oe(phy_dq_oe), .phy_dq_i(phy_dq_i),
    .phy_rwds_o(phy_rwds_o), .phy_rwds_oe(phy_rwds_oe), .phy_rwds_i(phy_rwds_i)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request, act as the PHY/write source, and record what happens.
  // strobes=1: RWDS=11 in CA phase (2x latency) and read strobes from pos 15.
  task automatic run_txn(input logic wr, input logic cs, input logic [31:0] addr,
                         input logic [7:0] len, input int drop_after, input bit strobes);
    int   pos = 0;
    int   high_run = 0;
    bit   in_cs = 1'b0;
    bit   dropping = 1'b0;
    bit   dropped = 1'b0;
    logic [1:0] exp_csn;
    exp_csn = cs ? 2'b01 : 2'b10;
    n_chunks = 0; n_wr = 0; n_rd = 0; n_done = 0; n_err = 0; bad_data = 0; bad_csn = 0;
    first_wr_pos = -1; done_cyc = -1; done_gap = -1; gap = -1;
    chunk_len[0] = 0; chunk_len[1] = 0; ca[0] = 48'd0; ca[1] = 48'd0;

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_reg_space = 1'b0;
    req_cs = cs; req_addr = addr; req_len = len;
    #1;
    check_eq("req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (phy_csn != 2'b11) begin
        if (!in_cs) begin
          in_cs = 1'b1; pos = 0;
          if (n_chunks == 1) gap = high_run;
          n_chunks++;
        end else begin
          pos++;
        end
        if (phy_csn != exp_csn) bad_csn++;
        if (n_chunks <= 2) chunk_len[n_chunks-1] = pos + 1;
        high_run = 0;
      end else begin
        in_cs = 1'b0;
        high_run++;
        if (dropping) begin dropping = 1'b0; dropped = 1'b1; end
      end
      wdat_valid = wr && !dropping;
      wdat       = 16'hC000 + 16'(n_wr);
      wmask      = 2'(n_wr);
      phy_rwds_i = 2'b00;
      phy_dq_i   = 16'h0000;
      if (in_cs && !wr && strobes) begin
        if (pos < 3) begin
          phy_rwds_i = 2'b11;
        end else if (pos >= 15 && pos < 15 + int'(len)) begin
          phy_rwds_i = 2'b10;
          phy_dq_i   = 16'h5A00 + 16'(pos - 15);
        end
      end
      #1;
      if (in_cs && pos < 3 && n_chunks <= 2 && phy_dq_oe)
        ca[n_chunks-1] = {ca[n_chunks-1][31:0], phy_dq_o};
      if (wdat_ready) begin
        if (!wdat_valid || phy_dq_o !== wdat || phy_rwds_o !== wmask ||
            !phy_dq_oe || !phy_rwds_oe) bad_data++;
        if (first_wr_pos < 0) first_wr_pos = pos;
        n_wr++;
        if (n_wr == drop_after && !dropped) dropping = 1'b1;
      end
      if (rdat_valid) begin
        if (rdat !== 16'h5A00 + 16'(n_rd)) bad_data++;
        n_rd++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) begin done_cyc = cyc; done_gap = high_run; end
      end
      if (err) begin
        n_err++;
        if (!done) bad_data++;
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
      @(negedge clk);
    end
    check_eq("txn_completes", 64'(done_cyc >= 0), 64'd1);
  endtask

  initial begin
    int low_cnt = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_reg_space = 1'b0;
    req_cs = 1'b0; req_addr = 32'd0; req_len = 8'd0; wdat = 16'd0; wmask = 2'd0;
    wdat_valid = 1'b0; phy_dq_i = 16'd0; phy_rwds_i = 2'b00;

    // reset: one cycle of rst, phy_rstn low for RESET_COUNT+1 cycles
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (phy_rstn !== 1'b0) break;
      if (i == 0) check_eq("rst_csn", 64'(phy_csn), 64'h3);
      if (i == 0) check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      low_cnt++;
      @(negedge clk);
    end
    check_eq("rstn_low_cycles", 64'(low_cnt), 64'd5);
    check_eq("idle_req_ready", 64'(req_ready), 64'd1);
    check_eq("idle_csn", 64'(phy_csn), 64'h3);
    check_eq("idle_done", 64'({done, err, rdat_valid}), 64'd0);

    // write 4 words, cs1, addr 0x10
    run_txn(1'b1, 1'b1, 32'h10, 8'd4, 0, 1'b0);
    check_eq("w4_ca", 64'(ca[0]), 64'h2000_0002_0000);
    check_eq("w4_chunks", 64'(n_chunks), 64'd1);
    check_eq("w4_wready", 64'(n_wr), 64'd4);
    check_eq("w4_first_pos", 64'(first_wr_pos), 64'd9);
    check_eq("w4_cs_len", 64'(chunk_len[0]), 64'd13);
    check_eq("w4_bad_csn", 64'(bad_csn), 64'd0);
    check_eq("w4_bad_data", 64'(bad_data), 64'd0);
    check_eq("w4_done", 64'(n_done), 64'd1);
    check_eq("w4_done_gap", 64'(done_gap), 64'd2);
    check_eq("w4_err", 64'(n_err), 64'd0);

    // read 8 words, cs0, addr 0x40, 2x latency
    run_txn(1'b0, 1'b0, 32'h40, 8'd8, 0, 1'b1);
    check_eq("r8_ca", 64'(ca[0]), 64'hA000_0008_0000);
    check_eq("r8_chunks", 64'(n_chunks), 64'd1);
    check_eq("r8_rvalid", 64'(n_rd), 64'd8);
    check_eq("r8_bad_data", 64'(bad_data), 64'd0);
    check_eq("r8_cs_len", 64'(chunk_len[0]), 64'd23);
    check_eq("r8_bad_csn", 64'(bad_csn), 64'd0);
    check_eq("r8_done", 64'(n_done), 64'd1);
    check_eq("r8_err", 64'(n_err), 64'd0);

    // write 100 words: split at 64 CS-low cycles
    run_txn(1'b1, 1'b0, 32'h100, 8'd100, 0, 1'b0);
    check_eq("w100_chunks", 64'(n_chunks), 64'd2);
    check_eq("w100_cs_len0", 64'(chunk_len[0]), 64'd64);
    check_eq("w100_ca0", 64'(ca[0]), 64'h2000_0020_0000);
    check_eq("w100_ca1", 64'(ca[1]), 64'h2000_0026_0007);
    check_eq("w100_gap", 64'(gap), 64'd2);
    check_eq("w100_wready", 64'(n_wr), 64'd100);
    check_eq("w100_bad_data", 64'(bad_data), 64'd0);
    check_eq("w100_done", 64'(n_done), 64'd1);

    // write 6 words, wdat_valid drops after word 3
    run_txn(1'b1, 1'b1, 32'h20, 8'd6, 3, 1'b0);
    check_eq("wu_chunks", 64'(n_chunks), 64'd2);
    check_eq("wu_cs_len0", 64'(chunk_len[0]), 64'd13);
    check_eq("wu_ca0", 64'(ca[0]), 64'h2000_0004_0000);
    check_eq("wu_ca1", 64'(ca[1]), 64'h2000_0004_0003);
    check_eq("wu_gap", 64'(gap), 64'd2);
    check_eq("wu_wready", 64'(n_wr), 64'd6);
    check_eq("wu_bad_data", 64'(bad_data), 64'd0);
    check_eq("wu_done", 64'(n_done), 64'd1);

    // read with no strobes: timeout after 32 READ cycles
    run_txn(1'b0, 1'b0, 32'h0, 8'd4, 0, 1'b0);
    check_eq("to_cs_len", 64'(chunk_len[0]), 64'd41);
    check_eq("to_rvalid", 64'(n_rd), 64'd0);
    check_eq("to_done", 64'(n_done), 64'd1);
    check_eq("to_err", 64'(n_err), 64'd1);
    check_eq("to_err_alone", 64'(bad_data), 64'd0);

    // zero length: done next cycle, no bus activity
    run_txn(1'b1, 1'b1, 32'h80, 8'd0, 0, 1'b0);
    check_eq("z_chunks", 64'(n_chunks), 64'd0);
    check_eq("z_done", 64'(n_done), 64'd1);
    check_eq("z_done_cyc", 64'(done_cyc), 64'd0);
    check_eq("z_wready", 64'(n_wr), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
